// File: rtl/demo_de0_sys_rl_source_adapter.sv
// rtl/demo_de0_sys_rl_source_adapter.sv - Avalon-ST source-side ready-latency adapter
//
// Buffers beats from a readyLatency-0 upstream source in a DEPTH-entry FIFO and
// drives a downstream sink with readyLatency = READY_LATENCY. A beat leaves only
// in the cycle exactly READY_LATENCY cycles after the sink raised out_ready.
//
// Ports:
//   clk            system clock, rising edge
//   reset          synchronous active-high reset
//   in_valid       upstream beat valid
//   in_ready       upstream ready (= !full)
//   in_data        upstream payload
//   out_ready      downstream ready (readyLatency READY_LATENCY)
//   out_valid      downstream beat valid
//   out_data       downstream payload
//   fill_level     FIFO occupancy, 0..DEPTH
//   stats_clear    (DEMO_RL_SOURCE_STATS_EN only) clears underrun_count
//   underrun_count (DEMO_RL_SOURCE_STATS_EN only) saturating count of lost slots
//
// Optional feature macro: DEMO_RL_SOURCE_STATS_EN

module demo_de0_sys_rl_source_adapter #(
    parameter int DATA_WIDTH    = 32,
    parameter int DEPTH         = 8,
    parameter int ADDR_WIDTH    = 3,
    parameter int READY_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  out_ready,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
`ifdef DEMO_RL_SOURCE_STATS_EN
    input  logic                  stats_clear,
    output logic [15:0]           underrun_count,
`endif
    output logic [ADDR_WIDTH:0]   fill_level
);

    if (READY_LATENCY < 1 || READY_LATENCY > 4) begin : g_bad_rl
        $error("demo_de0_sys_rl_source_adapter: READY_LATENCY must be 1..4");
    end
    if (DEPTH != (1 << ADDR_WIDTH)) begin : g_bad_depth
        $error("demo_de0_sys_rl_source_adapter: DEPTH must equal 2**ADDR_WIDTH");
    end

    logic [DATA_WIDTH-1:0]    mem [DEPTH];
    logic [ADDR_WIDTH-1:0]    wr_addr;
    logic [ADDR_WIDTH-1:0]    rd_addr;
    logic [ADDR_WIDTH-1:0]    wr_next;
    logic [ADDR_WIDTH-1:0]    rd_next;
    logic [ADDR_WIDTH-1:0]    ptr_diff;
    logic                     full;
    logic                     empty;
    logic [READY_LATENCY-1:0] rdy_sr;
    logic                     rdy_d;
    logic                     push;
    logic                     pop;

    // Last delay stage is out_ready as the sink saw it READY_LATENCY cycles ago;
    // that is the only cycle in which the sink is obliged to take a beat.
    assign rdy_d     = rdy_sr[READY_LATENCY-1];
    assign out_valid = rdy_d && !empty;
    assign out_data  = mem[rd_addr];
    assign in_ready  = !full;

    assign push    = in_valid && !full;
    assign pop     = out_valid;
    assign wr_next = wr_addr + ADDR_WIDTH'(1);
    assign rd_next = rd_addr + ADDR_WIDTH'(1);

    // Pointers alias when full, so the full flag overrides the difference.
    assign ptr_diff   = wr_addr - rd_addr;
    assign fill_level = full ? (ADDR_WIDTH+1)'(DEPTH) : {1'b0, ptr_diff};

    always_ff @(posedge clk) begin
        if (reset) begin
            rdy_sr <= '0;
        end else begin
            rdy_sr[0] <= out_ready;
            for (int k = 1; k < READY_LATENCY; k++) begin
                rdy_sr[k] <= rdy_sr[k-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_addr <= '0;
            rd_addr <= '0;
            full    <= 1'b0;
            empty   <= 1'b1;
        end else begin
            if (push) begin
                wr_addr <= wr_next;
            end
            if (pop) begin
                rd_addr <= rd_next;
            end
            // A simultaneous push and pop leaves occupancy, and so both flags, alone.
            if (push && !pop) begin
                empty <= 1'b0;
                if (wr_next == rd_addr) begin
                    full <= 1'b1;
                end
            end else if (pop && !push) begin
                full <= 1'b0;
                if (rd_next == wr_addr) begin
                    empty <= 1'b1;
                end
            end
        end
    end

    // Storage carries no reset; stale contents are never visible while empty.
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            mem[wr_addr] <= in_data;
        end
    end

`ifdef DEMO_RL_SOURCE_STATS_EN
    // Counts slots the sink offered while nothing was buffered.
    always_ff @(posedge clk) begin
        if (reset || stats_clear) begin
            underrun_count <= '0;
        end else if (rdy_d && empty && underrun_count != 16'hFFFF) begin
            underrun_count <= underrun_count + 16'd1;
        end
    end
`endif

endmodule
